dictmem_arbiter: RTL and testbench

DICTMEM_ARBITER -- requirements
Module: dictmem_arbiter

---
 rtl/dictmem_arbiter_if.sv | 33 +++
 rtl/dictmem_arbiter.sv | 96 +++++++++
 tb/tb_dictmem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dictmem_arbiter_if.sv
// Dictionary ROM arbiter bus: two requesters, synchronous ROM port, grant counters.
// Requests/grants are same-cycle; read data returns one cycle after grant, no backpressure.
interface dictmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              lock0;
  logic              lock1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [15:0]       gnt_cnt0;
  logic [15:0]       gnt_cnt1;

  modport master (
    output req0, req1, lock0, lock1, addr0, addr1, rom_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_addr, gnt_cnt0, gnt_cnt1
  );

  modport slave (
    input  req0, req1, lock0, lock1, addr0, addr1, rom_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, rom_addr, gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/dictmem_arbiter.sv
// Round-robin arbiter with bounded lock bursts sharing one synchronous dictionary ROM.
// Grant is combinational (0 cycles); rdata/rvalid follow 1 cycle later; requesters are never stalled mid-read.
module dictmem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input logic            clock,
  input logic            reset,
  dictmem_arbiter_if.slave bus
);
  localparam int BW = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

  logic              last_q, last_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              own_vld_q, own_vld_d;
  logic              own_id_q, own_id_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0]       gnt_cnt1_q, gnt_cnt1_d;

  logic gnt_any;
  logic gnt_id;
  logic last_lock;
  logic other_req;

  always_comb begin
    gnt_any    = 1'b0;
    gnt_id     = 1'b0;
    last_lock  = last_q ? bus.lock1 : bus.lock0;
    last_d     = last_q;
    burst_d    = '0;
    own_vld_d  = 1'b0;
    own_id_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;

    if (reset) begin
      if (bus.req0 && bus.req1) begin
        gnt_any = 1'b1;
        gnt_id  = (last_lock && (burst_q < BURST_LIM)) ? last_q : ~last_q;
      end else if (bus.req0 || bus.req1) begin
        gnt_any = 1'b1;
        gnt_id  = bus.req1;
      end
    end

    other_req = gnt_id ? bus.req0 : bus.req1;

    // Burst length counts the grant that took ownership, so BURST_MAX grants fit before a handover.
    if (gnt_any && other_req) begin
      burst_d = (gnt_id == last_q) ? burst_q + 1'b1 : BW'(1);
    end

    if (gnt_any) begin
      last_d     = gnt_id;
      own_vld_d  = 1'b1;
      own_id_d   = gnt_id;
      rom_addr_d = gnt_id ? bus.addr1 : bus.addr0;
      if (!gnt_id && gnt_cnt0_q != 16'hFFFF) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
      if (gnt_id && gnt_cnt1_q != 16'hFFFF)  gnt_cnt1_d = gnt_cnt1_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_q     <= 1'b1;
      burst_q    <= '0;
      own_vld_q  <= 1'b0;
      own_id_q   <= 1'b0;
      rom_addr_q <= '0;
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      last_q     <= last_d;
      burst_q    <= burst_d;
      own_vld_q  <= own_vld_d;
      own_id_q   <= own_id_d;
      rom_addr_q <= rom_addr_d;
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign bus.gnt0     = gnt_any & ~gnt_id;
  assign bus.gnt1     = gnt_any & gnt_id;
  assign bus.rom_addr = rom_addr_d;
  assign bus.rvalid0  = own_vld_q & ~own_id_q;
  assign bus.rvalid1  = own_vld_q & own_id_q;
  assign bus.rdata0   = bus.rvalid0 ? bus.rom_data : {DATA_W{1'b0}};
  assign bus.rdata1   = bus.rvalid1 ? bus.rom_data : {DATA_W{1'b0}};
  assign bus.gnt_cnt0 = gnt_cnt0_q;
  assign bus.gnt_cnt1 = gnt_cnt1_q;
endmodule

// File: tb/tb_dictmem_arbiter.sv
// Bench for dictmem_arbiter: directed scenarios plus randomized traffic against a history-based model.
module tb_dictmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BM = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dictmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dictmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return 32'hC0DE0000 ^ ({20'd0, a} * 32'h9E3779B1);
  endfunction

  // Synchronous ROM: word for the address sampled at an edge appears after it.
  always @(posedge clock) bus.rom_data <= rom_f(bus.rom_addr);

  int total = 0;
  int bad   = 0;

  // Reference model state: grant history, last winner, counters, pending read.
  int            m_holder;
  int            h_g[$];
  bit            h_o[$];
  int            m_cnt0, m_cnt1;
  int            m_own;
  logic [AW-1:0] m_own_addr;
  logic [AW-1:0] m_rom;
  int            e_g;
  logic [AW-1:0] e_rom;

  task automatic m_reset();
    m_holder = 1;
    h_g.delete();
    h_o.delete();
    m_cnt0 = 0;
    m_cnt1 = 0;
    m_own  = -1;
    m_own_addr = '0;
    m_rom  = '0;
  endtask

  task automatic m_predict();
    int run;
    logic lk;
    run = 0;
    e_g = -1;
    if (reset === 1'b1) begin
      if (bus.req0 && bus.req1) begin
        for (int i = h_g.size() - 1; i >= 0; i--) begin
          if (h_g[i] == m_holder && h_o[i]) run++;
          else break;
        end
        lk  = (m_holder == 1) ? bus.lock1 : bus.lock0;
        e_g = (lk && run < BM) ? m_holder : 1 - m_holder;
      end else if (bus.req0) begin
        e_g = 0;
      end else if (bus.req1) begin
        e_g = 1;
      end
    end
    e_rom = (e_g == 0) ? bus.addr0 : (e_g == 1) ? bus.addr1 : m_rom;
  endtask

  task automatic m_commit();
    bit other;
    if (reset !== 1'b1) begin
      m_reset();
    end else begin
      other = (e_g == 0) ? bus.req1 : bus.req0;
      h_g.push_back(e_g);
      h_o.push_back(e_g >= 0 && other);
      if (h_g.size() > 2 * BM + 4) begin
        void'(h_g.pop_front());
        void'(h_o.pop_front());
      end
      if (e_g >= 0) begin
        m_holder = e_g;
        m_rom    = e_rom;
      end
      if (e_g == 0 && m_cnt0 < 65535) m_cnt0++;
      if (e_g == 1 && m_cnt1 < 65535) m_cnt1++;
      m_own      = e_g;
      m_own_addr = e_rom;
    end
  endtask

  task automatic step();
    @(posedge clock);
    m_commit();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.lock0 = 1'b0; bus.lock1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    e_g = -1;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.addr0 = 12'd3; bus.addr1 = 12'd4;
    step();
    step();
    #1;
    total++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got gnt/rvalid=%b want 0000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1});
    end
    total++;
    if ({bus.rdata0, bus.rdata1} !== 64'd0) begin
      bad++;
      $display("FAIL reset_rdata: got %h %h want 0", bus.rdata0, bus.rdata1);
    end
    total++;
    if ({bus.rom_addr, bus.gnt_cnt0, bus.gnt_cnt1} !== 44'd0) begin
      bad++;
      $display("FAIL reset_regs: got rom_addr=%0d cnt0=%0d cnt1=%0d want 0", bus.rom_addr, bus.gnt_cnt0, bus.gnt_cnt1);
    end
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0]    eg [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
    logic [AW-1:0] er [5] = '{12'd5, 12'd9, 12'd5, 12'd9, 12'd9};
    logic [1:0]    ev [5] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.req0 = (k < 4); bus.req1 = (k < 4);
      bus.addr0 = 12'd5; bus.addr1 = 12'd9;
      #1;
      m_predict();
      total++;
      if ({bus.gnt0, bus.gnt1} !== eg[k]) begin
        bad++;
        $display("FAIL rr_gnt c%0d: got %b want %b", k + 1, {bus.gnt0, bus.gnt1}, eg[k]);
      end
      total++;
      if (bus.rom_addr !== er[k]) begin
        bad++;
        $display("FAIL rr_rom_addr c%0d: got %0d want %0d", k + 1, bus.rom_addr, er[k]);
      end
      total++;
      if ({bus.rvalid0, bus.rvalid1} !== ev[k]) begin
        bad++;
        $display("FAIL rr_rvalid c%0d: got %b want %b", k + 1, {bus.rvalid0, bus.rvalid1}, ev[k]);
      end
      total++;
      if (bus.rdata0 !== (ev[k][1] ? rom_f(12'd5) : 32'd0) ||
          bus.rdata1 !== (ev[k][0] ? rom_f(12'd9) : 32'd0)) begin
        bad++;
        $display("FAIL rr_rdata c%0d: got %h %h", k + 1, bus.rdata0, bus.rdata1);
      end
      step();
    end
  endtask

  task automatic test_lock_burst();
    logic [1:0] want;
    do_reset();
    bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.req1 = 1'b1; bus.lock1 = 1'b0;
    for (int k = 0; k < BM + 3; k++) begin
      bus.addr0 = 12'(k); bus.addr1 = 12'(100 + k);
      #1;
      want = (k == BM) ? 2'b01 : 2'b10;
      total++;
      if ({bus.gnt0, bus.gnt1} !== want) begin
        bad++;
        $display("FAIL lock_burst c%0d: got %b want %b", k + 1, {bus.gnt0, bus.gnt1}, want);
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_lock_alone();
    do_reset();
    bus.req1 = 1'b1; bus.lock1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.addr1 = 12'(k * 3);
      #1;
      total++;
      if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
        bad++;
        $display("FAIL lock_alone c%0d: got %b want 01", k + 1, {bus.gnt0, bus.gnt1});
      end
      step();
    end
    idle_inputs();
    #1;
    total++;
    if (bus.gnt_cnt1 !== 16'd10 || bus.gnt_cnt0 !== 16'd0) begin
      bad++;
      $display("FAIL lock_alone_cnt: got cnt0=%0d cnt1=%0d want 0 10", bus.gnt_cnt0, bus.gnt_cnt1);
    end
  endtask

  task automatic test_reset_after_grant();
    do_reset();
    bus.req0 = 1'b1; bus.addr0 = 12'd7;
    #1;
    total++;
    if ({bus.gnt0, bus.gnt1, bus.rom_addr} !== {2'b10, 12'd7}) begin
      bad++;
      $display("FAIL rst_grant: got gnt=%b rom_addr=%0d want 10 7", {bus.gnt0, bus.gnt1}, bus.rom_addr);
    end
    step();
    idle_inputs();
    reset = 1'b0;
    #1;
    total++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== rom_f(12'd7)) begin
      bad++;
      $display("FAIL rst_pre_read: got rvalid0=%b rdata0=%h want 1 %h", bus.rvalid0, bus.rdata0, rom_f(12'd7));
    end
    step();
    reset = 1'b1;
    #1;
    total++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b00 || bus.rdata0 !== 32'd0) begin
      bad++;
      $display("FAIL rst_after: got rvalid=%b rdata0=%h want 00 0", {bus.rvalid0, bus.rvalid1}, bus.rdata0);
    end
    total++;
    if ({bus.gnt_cnt0, bus.gnt_cnt1, bus.rom_addr} !== 44'd0) begin
      bad++;
      $display("FAIL rst_after_regs: got cnt0=%0d cnt1=%0d rom_addr=%0d want 0", bus.gnt_cnt0, bus.gnt_cnt1, bus.rom_addr);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    force dut.gnt_cnt0_q = 16'hFFFE;
    #1;
    release dut.gnt_cnt0_q;
    #1;
    total++;
    if (bus.gnt_cnt0 !== 16'hFFFE) begin
      bad++;
      $display("FAIL sat_preload: got %h want fffe", bus.gnt_cnt0);
    end
    for (int k = 0; k < 3; k++) begin
      bus.req0 = 1'b1; bus.addr0 = 12'(k);
      step();
      #1;
      total++;
      if (bus.gnt_cnt0 !== 16'hFFFF) begin
        bad++;
        $display("FAIL sat_cnt g%0d: got %h want ffff", k + 1, bus.gnt_cnt0);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int w0, w1;
    w0 = 0; w1 = 0;
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      bus.req0  = ($urandom_range(0, 9) < 7);
      bus.req1  = ($urandom_range(0, 9) < 7);
      bus.lock0 = ($urandom_range(0, 3) != 0);
      bus.lock1 = ($urandom_range(0, 3) != 0);
      bus.addr0 = AW'($urandom);
      bus.addr1 = AW'($urandom);
      #1;
      m_predict();
      total++;
      if (bus.gnt0 & bus.gnt1) begin
        bad++;
        $display("FAIL rnd_both n%0d: got gnt0=1 gnt1=1 want at most one", n);
      end
      total++;
      if ({bus.gnt0, bus.gnt1} !== {e_g == 0, e_g == 1}) begin
        bad++;
        $display("FAIL rnd_gnt n%0d: got %b want %b", n, {bus.gnt0, bus.gnt1}, {e_g == 0, e_g == 1});
      end
      total++;
      if (bus.rom_addr !== e_rom) begin
        bad++;
        $display("FAIL rnd_rom_addr n%0d: got %0d want %0d", n, bus.rom_addr, e_rom);
      end
      total++;
      if ({bus.rvalid0, bus.rvalid1} !== {m_own == 0, m_own == 1}) begin
        bad++;
        $display("FAIL rnd_rvalid n%0d: got %b want %b", n, {bus.rvalid0, bus.rvalid1}, {m_own == 0, m_own == 1});
      end
      total++;
      if (bus.rdata0 !== ((m_own == 0) ? rom_f(m_own_addr) : 32'd0) ||
          bus.rdata1 !== ((m_own == 1) ? rom_f(m_own_addr) : 32'd0)) begin
        bad++;
        $display("FAIL rnd_rdata n%0d: got %h %h addr %0d", n, bus.rdata0, bus.rdata1, m_own_addr);
      end
      total++;
      if (bus.gnt_cnt0 !== 16'(m_cnt0) || bus.gnt_cnt1 !== 16'(m_cnt1)) begin
        bad++;
        $display("FAIL rnd_cnt n%0d: got %0d %0d want %0d %0d", n, bus.gnt_cnt0, bus.gnt_cnt1, m_cnt0, m_cnt1);
      end
      w0 = (bus.req0 && !bus.gnt0) ? w0 + 1 : 0;
      w1 = (bus.req1 && !bus.gnt1) ? w1 + 1 : 0;
      total++;
      if (w0 > BM || w1 > BM) begin
        bad++;
        $display("FAIL rnd_wait n%0d: got waits %0d %0d want <= %0d", n, w0, w1, BM);
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    m_reset();
    e_g = -1;
    e_rom = '0;
    @(negedge clock);
    test_reset();
    test_round_robin();
    test_lock_burst();
    test_lock_alone();
    test_reset_after_grant();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
